// File: rtl/ahb_lite_master.sv
// ahb_lite_master: AHB-Lite single-transfer initiator with an in-order response FIFO
// Ports:
//   i_hclk, i_hreset              clock, synchronous active-high reset
//   i_cmd_valid / o_cmd_ready     command handshake
//   i_cmd_addr, i_cmd_write       byte address, 1=write 0=read
//   i_cmd_size, i_cmd_wdata       0=BYTE 1=HALFWORD 2=WORD, right-justified write data
//   o_rsp_valid / i_rsp_ready     response handshake (FIFO head)
//   o_rsp_rdata, o_rsp_error      right-justified zero-extended read data, error flag
//   o_haddr .. o_hwdata           AHB-Lite master outputs (HBURST=SINGLE, HPROT=4'b0011)
//   i_hrdata, i_hready, i_hresp   AHB-Lite slave inputs
module ahb_lite_master #(
    parameter int DATAWIDTH = 32,
    parameter int ADDRWIDTH = 32,
    parameter int RSP_DEPTH = 2
) (
    input  logic                 i_hclk,
    input  logic                 i_hreset,
    input  logic                 i_cmd_valid,
    output logic                 o_cmd_ready,
    input  logic [ADDRWIDTH-1:0] i_cmd_addr,
    input  logic                 i_cmd_write,
    input  logic [2:0]           i_cmd_size,
    input  logic [DATAWIDTH-1:0] i_cmd_wdata,
    output logic                 o_rsp_valid,
    input  logic                 i_rsp_ready,
    output logic [DATAWIDTH-1:0] o_rsp_rdata,
    output logic                 o_rsp_error,
    output logic [ADDRWIDTH-1:0] o_haddr,
    output logic [1:0]           o_htrans,
    output logic                 o_hwrite,
    output logic [2:0]           o_hsize,
    output logic [2:0]           o_hburst,
    output logic [3:0]           o_hprot,
    output logic [DATAWIDTH-1:0] o_hwdata,
    input  logic [DATAWIDTH-1:0] i_hrdata,
    input  logic                 i_hready,
    input  logic                 i_hresp
);
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] SIZE_BYTE     = 3'd0;
    localparam logic [2:0] SIZE_HALF     = 3'd1;
    localparam logic [2:0] SIZE_WORD     = 3'd2;
    localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CW = $clog2(RSP_DEPTH + 1) + 1;

    logic                 r_a_valid;
    logic [ADDRWIDTH-1:0] r_haddr;
    logic                 r_hwrite;
    logic [2:0]           r_hsize;
    logic [DATAWIDTH-1:0] r_a_wdata;
    logic                 r_d_valid;
    logic                 r_d_write;
    logic [1:0]           r_d_lane;
    logic [2:0]           r_d_size;
    logic [DATAWIDTH-1:0] r_hwdata;
    logic [DATAWIDTH:0]   r_mem [RSP_DEPTH];
    logic [PW-1:0]        r_wp;
    logic [PW-1:0]        r_rp;
    logic [CW-1:0]        r_cnt;

    logic                 w_err;
    logic                 w_a_adv;
    logic                 w_a_free;
    logic                 w_d_done;
    logic [CW-1:0]        w_used;
    logic                 w_misalign;
    logic                 w_acc;
    logic                 w_local;
    logic                 w_issue;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_push_err;
    logic [DATAWIDTH-1:0] w_push_rdata;
    logic [DATAWIDTH-1:0] w_rd_sh;
    logic [DATAWIDTH-1:0] w_rd;
    logic [DATAWIDTH-1:0] w_wlanes;

    // An ERROR response in the data phase withdraws the pending address phase
    // (IDLE on the bus) for both error cycles; it re-issues once the error is done.
    assign w_err    = r_d_valid & i_hresp;
    assign w_a_adv  = r_a_valid & i_hready & ~w_err;
    assign w_a_free = ~r_a_valid | w_a_adv;
    assign w_d_done = r_d_valid & i_hready;

    // Every accepted command owns a response slot until it is popped.
    assign w_used = r_cnt + CW'(r_a_valid) + CW'(r_d_valid);

    assign w_misalign = (i_cmd_size == SIZE_HALF && i_cmd_addr[0])
                      | (i_cmd_size == SIZE_WORD && i_cmd_addr[1:0] != 2'b00)
                      | (i_cmd_size > SIZE_WORD);

    // Misaligned commands answer locally, so they wait for an empty pipeline to keep order.
    assign o_cmd_ready = ~i_hreset & (w_used < CW'(RSP_DEPTH)) & w_a_free
                       & (~w_misalign | (~r_a_valid & ~r_d_valid));
    assign w_acc   = i_cmd_valid & o_cmd_ready;
    assign w_local = w_acc & w_misalign;
    assign w_issue = w_acc & ~w_misalign;

    assign w_wlanes = (i_cmd_size == SIZE_BYTE) ? {4{i_cmd_wdata[7:0]}} :
                      (i_cmd_size == SIZE_HALF) ? {2{i_cmd_wdata[15:0]}} : i_cmd_wdata;

    assign w_rd_sh = i_hrdata >> {r_d_lane, 3'b000};
    assign w_rd    = (r_d_size == SIZE_BYTE) ? DATAWIDTH'(w_rd_sh[7:0])  :
                     (r_d_size == SIZE_HALF) ? DATAWIDTH'(w_rd_sh[15:0]) : w_rd_sh;

    assign w_push       = w_d_done | w_local;
    assign w_pop        = o_rsp_valid & i_rsp_ready;
    assign w_push_err   = w_local | i_hresp;
    assign w_push_rdata = (w_push_err | r_d_write) ? '0 : w_rd;

    assign o_htrans = (r_a_valid & ~w_err) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign o_haddr  = r_haddr;
    assign o_hwrite = r_hwrite;
    assign o_hsize  = r_hsize;
    assign o_hwdata = r_hwdata;
    assign o_hburst = 3'b000;
    assign o_hprot  = 4'b0011;

    assign o_rsp_valid = (r_cnt != '0);
    assign o_rsp_rdata = o_rsp_valid ? r_mem[r_rp][DATAWIDTH-1:0] : '0;
    assign o_rsp_error = o_rsp_valid & r_mem[r_rp][DATAWIDTH];

    always_ff @(posedge i_hclk) begin
        if (i_hreset) begin
            r_a_valid <= 1'b0;
            r_haddr   <= '0;
            r_hwrite  <= 1'b0;
            r_hsize   <= '0;
            r_a_wdata <= '0;
            r_d_valid <= 1'b0;
            r_d_write <= 1'b0;
            r_d_lane  <= '0;
            r_d_size  <= '0;
            r_hwdata  <= '0;
        end else begin
            if (w_issue) begin
                r_a_valid <= 1'b1;
                r_haddr   <= i_cmd_addr;
                r_hwrite  <= i_cmd_write;
                r_hsize   <= i_cmd_size;
                r_a_wdata <= w_wlanes;
            end else if (w_a_adv) begin
                r_a_valid <= 1'b0;
            end
            if (w_a_adv) begin
                r_d_valid <= 1'b1;
                r_d_write <= r_hwrite;
                r_d_lane  <= r_haddr[1:0];
                r_d_size  <= r_hsize;
                if (r_hwrite)
                    r_hwdata <= r_a_wdata;
            end else if (w_d_done) begin
                r_d_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_hclk) begin
        if (i_hreset) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push)
                r_wp <= (r_wp == PW'(RSP_DEPTH - 1)) ? '0 : r_wp + 1'b1;
            if (w_pop)
                r_rp <= (r_rp == PW'(RSP_DEPTH - 1)) ? '0 : r_rp + 1'b1;
            r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge i_hclk) begin
        if (w_push)
            r_mem[r_wp] <= {w_push_err, w_push_rdata};
    end
endmodule

// File: tb/tb_ahb_lite_master.sv
// tb_ahb_lite_master: directed and randomized self-checking bench for ahb_lite_master
module tb_ahb_lite_master;
    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic        cmd_write;
    logic [2:0]  cmd_size;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    logic        hready;
    logic        hresp;

    int checks = 0;
    int failures = 0;

    logic [7:0]  smem [64];
    logic [7:0]  rmem [64];
    logic        sp_valid;
    logic [5:0]  sp_addr;
    logic        sp_write;
    logic [2:0]  sp_size;
    logic [32:0] expq [$];
    logic        acc;
    logic        gen;

    ahb_lite_master dut (
        .i_hclk(clk), .i_hreset(rst),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_addr(cmd_addr),
        .i_cmd_write(cmd_write), .i_cmd_size(cmd_size), .i_cmd_wdata(cmd_wdata),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_rdata(rsp_rdata),
        .o_rsp_error(rsp_error),
        .o_haddr(haddr), .o_htrans(htrans), .o_hwrite(hwrite), .o_hsize(hsize),
        .o_hburst(hburst), .o_hprot(hprot), .o_hwdata(hwdata),
        .i_hrdata(hrdata), .i_hready(hready), .i_hresp(hresp)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic smp;
        @(negedge clk);
    endtask

    function automatic logic misal(input logic [2:0] s, input logic [1:0] a);
        return (s == 3'd1 && a[0]) || (s == 3'd2 && a != 2'b00) || (s > 3'd2);
    endfunction

    function automatic logic [31:0] sword(input logic [5:0] a);
        logic [5:0] b;
        b = {a[5:2], 2'b00};
        return {smem[b + 3], smem[b + 2], smem[b + 1], smem[b]};
    endfunction

    // One single transfer with no wait states: address phase, data phase, response, pop.
    task automatic xfer(input string tag, input logic [31:0] a, input logic w, input logic [2:0] s,
                        input logic [31:0] wd, input logic [31:0] bus_rd,
                        input logic [31:0] exp_hw, input logic [31:0] exp_rd);
        cmd_valid = 1'b1; cmd_addr = a; cmd_write = w; cmd_size = s; cmd_wdata = wd;
        hready = 1'b1; hresp = 1'b0; rsp_ready = 1'b0;
        smp; chk({tag, "_ready"}, cmd_ready, 1);
        tick; cmd_valid = 1'b0;
        smp; chk({tag, "_htrans"}, htrans, 2'b10); chk({tag, "_haddr"}, haddr, a);
        chk({tag, "_hwrite"}, hwrite, w); chk({tag, "_hsize"}, hsize, s);
        tick; hrdata = bus_rd;
        smp; if (w) chk({tag, "_hwdata"}, hwdata, exp_hw);
        chk({tag, "_early_rsp"}, rsp_valid, 0); chk({tag, "_idle"}, htrans, 2'b00);
        tick;
        smp; chk({tag, "_rsp_valid"}, rsp_valid, 1); chk({tag, "_rsp_err"}, rsp_error, 0);
        chk({tag, "_rsp_rdata"}, rsp_rdata, exp_rd);
        tick; rsp_ready = 1'b1;
        smp;
        tick; rsp_ready = 1'b0;
        smp; chk({tag, "_popped"}, rsp_valid, 0);
        tick;
    endtask

    task automatic model_cmd;
        logic [31:0] v;
        int nb;
        nb = 1 << cmd_size;
        v = '0;
        if (misal(cmd_size, cmd_addr[1:0])) expq.push_back({1'b1, 32'h0});
        else if (cmd_write) begin
            for (int i = 0; i < nb; i++) rmem[cmd_addr[5:0] + i] = cmd_wdata[8*i +: 8];
            expq.push_back({1'b0, 32'h0});
        end else begin
            for (int i = 0; i < nb; i++) v[8*i +: 8] = rmem[cmd_addr[5:0] + i];
            expq.push_back({1'b0, v});
        end
    endtask

    task automatic slave_step;
        int b;
        if (sp_valid && hready) begin
            if (sp_write)
                for (int i = 0; i < (1 << sp_size); i++) begin
                    b = sp_addr + i;
                    smem[b] = hwdata[8*(b % 4) +: 8];
                end
            sp_valid = 1'b0;
        end
        if (htrans == 2'b10 && hready) begin
            chk("rand_bus_aligned", misal(hsize, haddr[1:0]), 0);
            sp_valid = 1'b1; sp_addr = haddr[5:0]; sp_write = hwrite; sp_size = hsize;
        end
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_write = 1'b0; cmd_size = '0;
        cmd_wdata = '0; rsp_ready = 1'b0; hrdata = '0; hready = 1'b1; hresp = 1'b0;
        repeat (3) tick;
        smp;
        chk("rst_htrans", htrans, 2'b00); chk("rst_haddr", haddr, 0); chk("rst_hwrite", hwrite, 0);
        chk("rst_hsize", hsize, 0); chk("rst_hwdata", hwdata, 0); chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0); chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_error", rsp_error, 0);
        chk("hburst", hburst, 3'b000); chk("hprot", hprot, 4'b0011);
        tick; rst = 1'b0;

        xfer("wr_word", 32'h100, 1'b1, 3'd2, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 32'h0);
        xfer("wr_byte", 32'h103, 1'b1, 3'd0, 32'h000000A5, 32'h0, 32'hA5A5A5A5, 32'h0);
        xfer("rd_byte", 32'h103, 1'b0, 3'd0, 32'h0, 32'hA5123456, 32'h0, 32'h000000A5);
        xfer("wr_half", 32'h102, 1'b1, 3'd1, 32'h0000C3D4, 32'h0, 32'hC3D4C3D4, 32'h0);
        xfer("rd_half", 32'h102, 1'b0, 3'd1, 32'h0, 32'hBEEF1234, 32'h0, 32'h0000BEEF);
        xfer("rd_byte1", 32'h101, 1'b0, 3'd0, 32'h0, 32'h00007700, 32'h0, 32'h00000077);

        // back-to-back reads, two wait states on the first data phase
        cmd_valid = 1'b1; cmd_addr = 32'h0; cmd_write = 1'b0; cmd_size = 3'd2;
        smp; chk("b2b_rdy0", cmd_ready, 1);
        tick; cmd_addr = 32'h4;
        smp; chk("b2b_rdy1", cmd_ready, 1); chk("b2b_a0", haddr, 32'h0);
        tick; cmd_valid = 1'b0; hready = 1'b0;
        smp; chk("b2b_w1_trans", htrans, 2'b10); chk("b2b_w1_addr", haddr, 32'h4);
        tick;
        smp; chk("b2b_w2_trans", htrans, 2'b10); chk("b2b_w2_addr", haddr, 32'h4);
        chk("b2b_w2_rsp", rsp_valid, 0);
        tick; hready = 1'b1; hrdata = 32'h11111111;
        smp; chk("b2b_end_addr", haddr, 32'h4);
        tick; hrdata = 32'h22222222;
        smp; chk("b2b_rsp0_valid", rsp_valid, 1); chk("b2b_rsp0", rsp_rdata, 32'h11111111);
        tick; rsp_ready = 1'b1;
        smp; chk("b2b_rsp0_hold", rsp_rdata, 32'h11111111);
        tick;
        smp; chk("b2b_rsp1_valid", rsp_valid, 1); chk("b2b_rsp1", rsp_rdata, 32'h22222222);
        tick; rsp_ready = 1'b0;
        smp; chk("b2b_empty", rsp_valid, 0);
        tick;

        // response back-pressure exhausts credits
        cmd_valid = 1'b1; cmd_addr = 32'h10;
        smp; chk("cr_rdy0", cmd_ready, 1);
        tick; cmd_addr = 32'h14;
        smp; chk("cr_rdy1", cmd_ready, 1);
        tick; cmd_addr = 32'h18; hrdata = 32'hA;
        smp; chk("cr_full0", cmd_ready, 0);
        tick; hrdata = 32'hB;
        smp; chk("cr_full1", cmd_ready, 0);
        tick;
        smp; chk("cr_full2", cmd_ready, 0); chk("cr_rspv", rsp_valid, 1);
        tick;
        smp; chk("cr_full3", cmd_ready, 0); chk("cr_no_issue", htrans, 2'b00);
        chk("cr_head0", rsp_rdata, 32'hA);
        tick; rsp_ready = 1'b1;
        smp; chk("cr_full4", cmd_ready, 0);
        tick; rsp_ready = 1'b0;
        smp; chk("cr_after_pop", cmd_ready, 1); chk("cr_head1", rsp_rdata, 32'hB);
        tick; cmd_valid = 1'b0; hrdata = 32'hC;
        smp; chk("cr_third_trans", htrans, 2'b10); chk("cr_third_addr", haddr, 32'h18);
        tick;
        smp;
        tick; rsp_ready = 1'b1;
        smp; chk("cr_drain0", rsp_rdata, 32'hB);
        tick;
        smp; chk("cr_drain1", rsp_rdata, 32'hC);
        tick; rsp_ready = 1'b0;
        smp; chk("cr_empty", rsp_valid, 0);
        tick;

        // slave ERROR on 0x200 with 0x204 pending in its address phase
        cmd_valid = 1'b1; cmd_addr = 32'h200;
        smp;
        tick; cmd_addr = 32'h204;
        smp; chk("err_rdy1", cmd_ready, 1);
        tick; cmd_valid = 1'b0; hresp = 1'b1; hready = 1'b0;
        smp; chk("err_c1_idle", htrans, 2'b00); chk("err_c1_rdy", cmd_ready, 0);
        tick; hready = 1'b1;
        smp; chk("err_c2_idle", htrans, 2'b00);
        tick; hresp = 1'b0; hrdata = 32'h5555AAAA;
        smp; chk("err_reissue", htrans, 2'b10); chk("err_reissue_addr", haddr, 32'h204);
        chk("err_rsp_valid", rsp_valid, 1); chk("err_rsp_error", rsp_error, 1);
        chk("err_rsp_rdata", rsp_rdata, 0);
        tick;
        smp; chk("err_data_idle", htrans, 2'b00);
        tick; rsp_ready = 1'b1;
        smp; chk("err_head", rsp_error, 1);
        tick;
        smp; chk("err_ok_valid", rsp_valid, 1); chk("err_ok_error", rsp_error, 0);
        chk("err_ok_rdata", rsp_rdata, 32'h5555AAAA);
        tick; rsp_ready = 1'b0;
        smp; chk("err_empty", rsp_valid, 0);
        tick;

        // misaligned halfword while idle
        cmd_valid = 1'b1; cmd_addr = 32'h101; cmd_write = 1'b1; cmd_size = 3'd1; cmd_wdata = 32'h1234;
        smp; chk("mis_rdy", cmd_ready, 1);
        tick; cmd_valid = 1'b0; rsp_ready = 1'b1;
        smp; chk("mis_no_bus", htrans, 2'b00); chk("mis_rsp_valid", rsp_valid, 1);
        chk("mis_rsp_error", rsp_error, 1); chk("mis_rsp_rdata", rsp_rdata, 0);
        tick; rsp_ready = 1'b0;
        smp; chk("mis_empty", rsp_valid, 0);
        tick;

        // misaligned word waits for the pipeline to drain
        cmd_valid = 1'b1; cmd_addr = 32'h0; cmd_write = 1'b0; cmd_size = 3'd2; hrdata = 32'h77;
        smp;
        tick; cmd_addr = 32'h2;
        smp; chk("misb_rdy_a", cmd_ready, 0);
        tick;
        smp; chk("misb_rdy_d", cmd_ready, 0);
        tick;
        smp; chk("misb_rdy_idle", cmd_ready, 1);
        tick; cmd_valid = 1'b0;
        smp; chk("misb_no_bus", htrans, 2'b00); chk("misb_head", rsp_rdata, 32'h77);
        chk("misb_head_err", rsp_error, 0);
        tick; rsp_ready = 1'b1;
        smp;
        tick;
        smp; chk("misb_second_err", rsp_error, 1); chk("misb_second_rdata", rsp_rdata, 0);
        tick; rsp_ready = 1'b0;
        smp; chk("misb_empty", rsp_valid, 0);
        tick;

        // reset in the middle of a write data phase
        cmd_valid = 1'b1; cmd_addr = 32'h40; cmd_write = 1'b1; cmd_size = 3'd2; cmd_wdata = 32'hCAFEF00D;
        smp;
        tick; cmd_valid = 1'b0;
        smp;
        tick; rst = 1'b1;
        smp; chk("rr_hwdata_before", hwdata, 32'hCAFEF00D);
        tick;
        smp; chk("rr_htrans", htrans, 2'b00); chk("rr_haddr", haddr, 0); chk("rr_hwrite", hwrite, 0);
        chk("rr_hsize", hsize, 0); chk("rr_hwdata", hwdata, 0); chk("rr_cmd_ready", cmd_ready, 0);
        chk("rr_rsp_valid", rsp_valid, 0); chk("rr_rsp_rdata", rsp_rdata, 0); chk("rr_rsp_error", rsp_error, 0);
        tick; rst = 1'b0;
        smp;
        tick;
        smp; chk("rr_no_rsp", rsp_valid, 0); chk("rr_no_bus", htrans, 2'b00);
        tick;

        // randomized traffic against a byte-level memory model
        for (int i = 0; i < 64; i++) begin
            smem[i] = 8'($urandom);
            rmem[i] = smem[i];
        end
        sp_valid = 1'b0; sp_addr = '0; sp_write = 1'b0; sp_size = '0;
        acc = 1'b0; gen = 1'b1;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            if (cyc >= 1200) gen = 1'b0;
            if (!gen && expq.size() == 0 && !cmd_valid && !sp_valid) break;
            if (acc) cmd_valid = 1'b0;
            if (!cmd_valid && gen && $urandom_range(0, 2) != 0) begin
                int sel;
                sel = $urandom_range(0, 9);
                cmd_valid = 1'b1;
                cmd_addr  = 32'($urandom_range(0, 63));
                cmd_write = 1'($urandom_range(0, 1));
                cmd_size  = (sel < 3) ? 3'd0 : (sel < 6) ? 3'd1 : (sel < 9) ? 3'd2 : 3'd3;
                cmd_wdata = $urandom;
            end
            rsp_ready = gen ? 1'($urandom_range(0, 1)) : 1'b1;
            hready = sp_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
            hrdata = (sp_valid && !sp_write) ? sword(sp_addr) : $urandom;
            smp;
            acc = cmd_valid && cmd_ready;
            if (acc) model_cmd();
            if (rsp_valid && rsp_ready) begin
                chk("rand_rsp_expected", expq.size() != 0, 1);
                if (expq.size() != 0) chk("rand_rsp", {rsp_error, rsp_rdata}, expq.pop_front());
            end
            slave_step();
            tick;
        end
        chk("drain_queue_empty", expq.size(), 0);
        chk("drain_cmd_done", cmd_valid, 0);
        chk("drain_rsp_empty", rsp_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
